chicken_turn_fsm: RTL and testbench
===================================

Name: chicken_turn_fsm

Overview:
- Parametrised successor to the single-player game control FSM, for the board game controller.
- Sequences a multi-player turn loop: card select, card reveal, match judgement, chicken advance, turn pass, win.
- Tracks every player's board position and detects the winner.
- Sits between the keypad decoder / card-match comparator and the display/LED drivers.

Parameters:
- NUM_PLAYERS, 4, number of players, 2..8.
- BOARD_LEN, 24, number of tiles on the track, 4..64; finish tile is BOARD_LEN-1.
- KEY_W, 4, width of the key code; all-ones code means "no key".
- TIMEOUT_CYC, 50000000, SELECT-state cycles before a forced turn pass (used only with the optional feature).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, level; begins a game from IDLE.
- key, input, KEY_W, keypad code; all-ones means idle.
- match_valid, input, 1, one-cycle pulse from the comparator.
- match, input, 1, revealed card equals target tile; sampled with match_valid.
- state, output, 3, current FSM state encoding.
- cur_player, output, PW, active player; PW = max(1, clog2(NUM_PLAYERS)).
- sel_card, output, KEY_W, latched selected card.
- reveal, output, 1, high while the card is shown.
- pos_flat, output, NUM_PLAYERS*POSW, positions; player i at bits [i*POSW +: POSW]; POSW = clog2(BOARD_LEN).
- winner_valid, output, 1, high in WIN.
- winner, output, PW, winning player, valid with winner_valid.

Behaviour:
- Clocking and reset: rst synchronous, active-high, clock clk, has priority over everything, including mid-turn.
- Reset values: state=IDLE, cur_player=0, sel_card=0, reveal=0, all positions 0, winner_valid=0, winner=0.
- All outputs are registered.
- Key press detection: a press is key != all-ones while the previous-cycle key == all-ones. Held keys produce exactly one press.
- IDLE: start=1 -> SELECT next cycle, positions cleared, cur_player=0.
- SELECT:
  - On a press, latch sel_card=key -> REVEAL.
  - Otherwise stay.
- REVEAL:
  - reveal=1 for exactly one cycle -> JUDGE.
  - reveal stays 1 throughout JUDGE.
- JUDGE, waiting for match_valid:
  - match=1 -> ADVANCE.
  - match=0 -> NEXT.
  - reveal drops to 0 on exit.
  - Key presses in JUDGE are ignored.
- ADVANCE, one cycle:
  - pos[cur_player] += 1.
  - If the new pos == BOARD_LEN-1: winner=cur_player, then -> WIN.
  - Else -> SELECT; the same player continues the turn.
  - Position never exceeds BOARD_LEN-1; there is no wrap-around.
- NEXT, one cycle:
  - cur_player = (cur_player == NUM_PLAYERS-1) ? 0 : cur_player+1 -> SELECT.
- WIN:
  - winner_valid=1; hold until rst. start is ignored.
  - winner_valid drops on the cycle after rst is sampled.
- Encoding: IDLE=0, SELECT=1, REVEAL=2, JUDGE=3, ADVANCE=4, NEXT=5, WIN=6. Code 7 is unreachable and recovers to IDLE.
- Latency: press to reveal=1 is 1 cycle; match_valid to pos update is 2 cycles.
- A match_valid outside JUDGE is ignored.

Optional Feature:
- Macro TURN_TIMEOUT_EN.
- Defined:
  - A counter runs in SELECT.
  - When TIMEOUT_CYC cycles pass with no press -> NEXT.
  - The counter clears on every state entry.
  - A press on the timeout cycle wins: go to REVEAL.
- Undefined: no counter; SELECT waits indefinitely and TIMEOUT_CYC is unused.

Decomposition:
- Package chicken_pkg holds:
  - state encoding constants;
  - KEY_NONE all-ones function/constant;
  - PW/POSW width helper functions.
- One sub-module, key_press_detect: registers the key, emits a one-cycle press pulse and the key value.

Test Plan:
- Reset mid-JUDGE with pos[1]=5 -> next cycle state=IDLE, all pos=0, reveal=0.
- NUM_PLAYERS=3: player0 key=3 -> sel_card=3, reveal 1 cycle later; match_valid with match=0 -> cur_player=1. After a further miss by player2, cur_player wraps to 0.
- Key held at 4'h5 for 10 cycles -> exactly one SELECT->REVEAL; no second press until key returns to 4'hF.
- BOARD_LEN=4: three consecutive matches by player2 -> pos[2]=3, winner=2, winner_valid=1; start pulses ignored.
- match_valid pulse while in SELECT -> no state or position change.
- TURN_TIMEOUT_EN with TIMEOUT_CYC=8:
  - no key for 8 cycles -> cur_player advances;
  - press on cycle 8 -> REVEAL instead.

Source files
------------

// File: rtl/chicken_pkg.sv
// Shared state encoding and width helpers for the multi-player chicken turn controller.
package chicken_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_REVEAL  = 3'd2,
    ST_JUDGE   = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_NEXT    = 3'd5,
    ST_WIN     = 3'd6
  } state_t;

  function automatic int pw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int posw_of(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  // All-ones key code of width w, meaning "no key pressed".
  function automatic logic [63:0] key_none(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/chicken_turn_fsm_key_press_detect.sv
// Keypad edge detector: one-cycle press pulse on an idle-to-key transition, plus the key value.
module key_press_detect
  import chicken_pkg::*;
#(
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic             press,
  output logic [KEY_W-1:0] key_val
);

  localparam logic [KEY_W-1:0] KEY_NONE = KEY_W'(key_none(KEY_W));

  logic [KEY_W-1:0] key_q;

  always_ff @(posedge clk) begin
    if (rst) key_q <= KEY_NONE;
    else     key_q <= key;
  end

  assign press   = (key != KEY_NONE) && (key_q == KEY_NONE);
  assign key_val = key;

endmodule

// File: rtl/chicken_turn_fsm.sv
// Multi-player turn sequencer: select, reveal, judge, advance/pass, win.
// Optional SELECT timeout with forced turn pass when TURN_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// SELECT  | waiting for the active player's key press
// REVEAL  | card shown, one cycle
// JUDGE   | card shown, waiting for comparator result
// ADVANCE | move active chicken one tile
// NEXT    | pass turn to the next player
// WIN     | winner latched, held until reset
module chicken_turn_fsm
  import chicken_pkg::*;
#(
  parameter  int NUM_PLAYERS = 4,
  parameter  int BOARD_LEN   = 24,
  parameter  int KEY_W       = 4,
  parameter  int TIMEOUT_CYC = 50000000,
  localparam int PW          = pw_of(NUM_PLAYERS),
  localparam int POSW        = posw_of(BOARD_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [KEY_W-1:0]            key,
  input  logic                        match_valid,
  input  logic                        match,
  output logic [2:0]                  state,
  output logic [PW-1:0]               cur_player,
  output logic [KEY_W-1:0]            sel_card,
  output logic                        reveal,
  output logic [NUM_PLAYERS*POSW-1:0] pos_flat,
  output logic                        winner_valid,
  output logic [PW-1:0]               winner
);

  localparam logic [POSW-1:0] LAST_TILE   = POSW'(BOARD_LEN - 1);
  localparam logic [PW-1:0]   LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  state_t           st;
  logic             press;
  logic [KEY_W-1:0] key_val;
  logic [POSW-1:0]  cur_pos;

  key_press_detect #(.KEY_W(KEY_W)) u_kpd (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .press   (press),
    .key_val (key_val)
  );

  assign cur_pos = pos_flat[int'(cur_player)*POSW +: POSW];
  assign state   = st;

`ifdef TURN_TIMEOUT_EN
  localparam int          TW       = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      cur_player   <= '0;
      sel_card     <= '0;
      reveal       <= 1'b0;
      pos_flat     <= '0;
      winner_valid <= 1'b0;
      winner       <= '0;
`ifdef TURN_TIMEOUT_EN
      tmr          <= TMR_LOAD;
`endif
    end else begin
`ifdef TURN_TIMEOUT_EN
      // Reload on every cycle outside a continuing SELECT wait, so each entry starts fresh.
      tmr <= TMR_LOAD;
`endif
      case (st)
        ST_IDLE: begin
          if (start) begin
            st         <= ST_SELECT;
            pos_flat   <= '0;
            cur_player <= '0;
          end
        end
        ST_SELECT: begin
          if (press) begin
            sel_card <= key_val;
            reveal   <= 1'b1;
            st       <= ST_REVEAL;
          end
`ifdef TURN_TIMEOUT_EN
          else if (tmr == '0) st <= ST_NEXT;
          else                tmr <= tmr - TW'(1);
`endif
        end
        ST_REVEAL: st <= ST_JUDGE;
        ST_JUDGE: begin
          if (match_valid) begin
            reveal <= 1'b0;
            st     <= match ? ST_ADVANCE : ST_NEXT;
          end
        end
        ST_ADVANCE: begin
          // Saturating move: reaching the last tile ends the game.
          if (cur_pos >= LAST_TILE - POSW'(1)) begin
            pos_flat[int'(cur_player)*POSW +: POSW] <= LAST_TILE;
            winner       <= cur_player;
            winner_valid <= 1'b1;
            st           <= ST_WIN;
          end else begin
            pos_flat[int'(cur_player)*POSW +: POSW] <= cur_pos + POSW'(1);
            st <= ST_SELECT;
          end
        end
        ST_NEXT: begin
          cur_player <= (cur_player == LAST_PLAYER) ? '0 : cur_player + PW'(1);
          st         <= ST_SELECT;
        end
        ST_WIN: st <= ST_WIN;
        default: begin
          st           <= ST_IDLE;
          reveal       <= 1'b0;
          winner_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chicken_turn_fsm.sv
// Scoreboard bench for chicken_turn_fsm (3 players, 4-tile board, 8-cycle timeout when enabled).
module tb_chicken_turn_fsm;

  localparam logic [2:0] S_IDLE = 3'd0, S_SELECT = 3'd1, S_REVEAL = 3'd2, S_JUDGE = 3'd3,
                         S_ADV = 3'd4, S_NEXT = 3'd5, S_WIN = 3'd6;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cp;
    logic [3:0] sc;
    logic       rv;
    logic [5:0] pos;
    logic       wv;
    logic [1:0] w;
  } obs_t;

  typedef struct {
    obs_t  v;
    string name;
  } exp_t;

  logic       clk, rst, start, match_valid, match;
  logic [3:0] key;
  logic [2:0] state;
  logic [1:0] cur_player, winner;
  logic [3:0] sel_card;
  logic       reveal, winner_valid;
  logic [5:0] pos_flat;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  exp_t q[$];

  chicken_turn_fsm #(.NUM_PLAYERS(3), .BOARD_LEN(4), .KEY_W(4), .TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key          (key),
    .match_valid  (match_valid),
    .match        (match),
    .state        (state),
    .cur_player   (cur_player),
    .sel_card     (sel_card),
    .reveal       (reveal),
    .pos_flat     (pos_flat),
    .winner_valid (winner_valid),
    .winner       (winner)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Monitor: every change of the observed output vector must match the next expected record.
  initial begin
    obs_t cur, prev;
    exp_t e;
    prev = '1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = '{state, cur_player, sel_card, reveal, pos_flat, winner_valid, winner};
        if (cur != prev) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got st=%0d cp=%0d sc=%h rv=%0b pos=%h wv=%0b w=%0d",
                     cur.st, cur.cp, cur.sc, cur.rv, cur.pos, cur.wv, cur.w);
          end else begin
            e = q.pop_front();
            if (cur != e.v) begin
              errors++;
              $display("FAIL %s got st=%0d cp=%0d sc=%h rv=%0b pos=%h wv=%0b w=%0d expected st=%0d cp=%0d sc=%h rv=%0b pos=%h wv=%0b w=%0d",
                       e.name, cur.st, cur.cp, cur.sc, cur.rv, cur.pos, cur.wv, cur.w,
                       e.v.st, e.v.cp, e.v.sc, e.v.rv, e.v.pos, e.v.wv, e.v.w);
            end
          end
          prev = cur;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [2:0] st, input logic [1:0] cp,
                      input logic [3:0] sc, input logic rv, input logic [5:0] pos,
                      input logic wv, input logic [1:0] w);
    exp_t e;
    e.v    = '{st, cp, sc, rv, pos, wv, w};
    e.name = name;
    q.push_back(e);
  endtask

  task automatic press_reveal(input string name, input logic [3:0] k, input logic [1:0] cp,
                              input logic [5:0] pos);
    push({name, "_reveal"}, S_REVEAL, cp, k, 1'b1, pos, 1'b0, 2'd0);
    push({name, "_judge"}, S_JUDGE, cp, k, 1'b1, pos, 1'b0, 2'd0);
    key = k;
    cyc(1);
    key = 4'hF;
    cyc(1);
  endtask

  task automatic judge(input string name, input logic hit, input logic [1:0] cp, input logic [3:0] sc,
                       input logic [5:0] pos, input logic [1:0] next_cp, input logic [5:0] next_pos,
                       input logic win);
    push({name, hit ? "_advance" : "_next"}, hit ? S_ADV : S_NEXT, cp, sc, 1'b0, pos, 1'b0, 2'd0);
    push({name, win ? "_win" : "_select"}, win ? S_WIN : S_SELECT, next_cp, sc, 1'b0, next_pos,
         win, win ? cp : 2'd0);
    match_valid = 1'b1;
    match       = hit;
    cyc(1);
    match_valid = 1'b0;
    match       = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1; key = 4'hF; start = 0; match_valid = 0; match = 0;
    cyc(2);
    push("reset", S_IDLE, 0, 4'h0, 0, 6'h00, 0, 0);
    mon_en = 1;
    rst = 0;
    cyc(2);

    // Game 1: misses, held key, stray match_valid, player2 wins.
    push("g1_start", S_SELECT, 0, 4'h0, 0, 6'h00, 0, 0);
    start = 1; cyc(1); start = 0;
    press_reveal("g1_p0", 4'h3, 0, 6'h00);
    judge("g1_p0", 0, 0, 4'h3, 6'h00, 1, 6'h00, 0);

    push("held_reveal", S_REVEAL, 1, 4'h5, 1, 6'h00, 0, 0);
    push("held_judge", S_JUDGE, 1, 4'h5, 1, 6'h00, 0, 0);
    key = 4'h5;
    cyc(5);
    judge("held_p1", 0, 1, 4'h5, 6'h00, 2, 6'h00, 0);
    cyc(3);
    key = 4'hF;
    cyc(1);

    match_valid = 1; match = 1; cyc(1);
    match_valid = 0; match = 0; cyc(1);

    press_reveal("g1_p2_a", 4'h7, 2, 6'h00);
    judge("g1_p2_a", 1, 2, 4'h7, 6'h00, 2, 6'h10, 0);
    press_reveal("g1_p2_b", 4'h7, 2, 6'h10);
    judge("g1_p2_b", 1, 2, 4'h7, 6'h10, 2, 6'h20, 0);
    press_reveal("g1_p2_c", 4'h7, 2, 6'h20);
    judge("g1_p2_c", 1, 2, 4'h7, 6'h20, 2, 6'h30, 1);

    start = 1; cyc(1);
    start = 0; key = 4'h3; cyc(1);
    key = 4'hF; start = 1; cyc(2);
    start = 0; cyc(1);

    push("rst_from_win", S_IDLE, 0, 4'h0, 0, 6'h00, 0, 0);
    rst = 1; cyc(1); rst = 0; cyc(1);

    // Game 2: player1 moves twice, then reset lands mid-JUDGE.
    push("g2_start", S_SELECT, 0, 4'h0, 0, 6'h00, 0, 0);
    start = 1; cyc(1); start = 0;
    press_reveal("g2_p0", 4'h1, 0, 6'h00);
    judge("g2_p0", 0, 0, 4'h1, 6'h00, 1, 6'h00, 0);
    press_reveal("g2_p1_a", 4'h2, 1, 6'h00);
    judge("g2_p1_a", 1, 1, 4'h2, 6'h00, 1, 6'h04, 0);
    press_reveal("g2_p1_b", 4'h2, 1, 6'h04);
    judge("g2_p1_b", 1, 1, 4'h2, 6'h04, 1, 6'h08, 0);
    press_reveal("g2_p1_c", 4'h9, 1, 6'h08);
    push("rst_mid_judge", S_IDLE, 0, 4'h0, 0, 6'h00, 0, 0);
    rst = 1; match_valid = 1; match = 1; cyc(1);
    rst = 0; match_valid = 0; match = 0; cyc(1);

    // Game 3: three misses wrap cur_player back to 0.
    push("g3_start", S_SELECT, 0, 4'h0, 0, 6'h00, 0, 0);
    start = 1; cyc(1); start = 0;
    press_reveal("g3_p0", 4'hA, 0, 6'h00);
    judge("g3_p0", 0, 0, 4'hA, 6'h00, 1, 6'h00, 0);
    press_reveal("g3_p1", 4'hB, 1, 6'h00);
    judge("g3_p1", 0, 1, 4'hB, 6'h00, 2, 6'h00, 0);
    press_reveal("g3_p2", 4'hC, 2, 6'h00);
    judge("g3_wrap", 0, 2, 4'hC, 6'h00, 0, 6'h00, 0);

`ifdef TURN_TIMEOUT_EN
    push("timeout_next", S_NEXT, 0, 4'hC, 0, 6'h00, 0, 0);
    push("timeout_select", S_SELECT, 1, 4'hC, 0, 6'h00, 0, 0);
    cyc(9);
    push("late_press_reveal", S_REVEAL, 1, 4'hD, 1, 6'h00, 0, 0);
    push("late_press_judge", S_JUDGE, 1, 4'hD, 1, 6'h00, 0, 0);
    cyc(7);
    key = 4'hD; cyc(1);
    key = 4'hF; cyc(1);
    judge("late_p1", 0, 1, 4'hD, 6'h00, 2, 6'h00, 0);
`else
    cyc(20);
    press_reveal("no_timeout", 4'hD, 0, 6'h00);
    judge("no_timeout", 0, 0, 4'hD, 6'h00, 1, 6'h00, 0);
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending records expected 0, next=%s", q.size(), q[0].name);
    end
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
